bldcm_ramp_core: RTL

Second-generation six-step BLDC commutation core with a parametrised divider width and a signed direction input. Adds two behaviours to the existing core: a speed ramp that slews the commutation divider toward a target by a fixed step on each commutation, and per-leg dead-time insertion with registered gate outputs. It sits between the register interface (divider, ramp, dead-time and phase-load controls) and the gate-driver pins.

---
 rtl/bldcm_pkg.sv | 35 +++
 rtl/bldcm_deadtime_leg.sv | 99 +++++++++
 rtl/bldcm_ramp_core.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/bldcm_pkg.sv
// Shared constants for the six-step BLDC commutation core:
// phase stages, leg FSM encoding, gate bit order and the demand table.
package bldcm_pkg;

    localparam int         PHASE_COUNT = 6;
    localparam logic [2:0] PHASE_MAX   = 3'd5;

    localparam logic [1:0] LEG_OFF  = 2'd0;
    localparam logic [1:0] LEG_DEAD = 2'd1;
    localparam logic [1:0] LEG_ON_H = 2'd2;
    localparam logic [1:0] LEG_ON_L = 2'd3;

    localparam int GATE_UH = 0;
    localparam int GATE_UL = 1;
    localparam int GATE_VH = 2;
    localparam int GATE_VL = 3;
    localparam int GATE_WH = 4;
    localparam int GATE_WL = 5;

    function automatic logic [5:0] demand_of(input logic [2:0] phase);
        logic [5:0] d;
        d = '0;
        case (phase)
            3'd0: begin d[GATE_UH] = 1'b1; d[GATE_VL] = 1'b1; end
            3'd1: begin d[GATE_UH] = 1'b1; d[GATE_WL] = 1'b1; end
            3'd2: begin d[GATE_VH] = 1'b1; d[GATE_WL] = 1'b1; end
            3'd3: begin d[GATE_VH] = 1'b1; d[GATE_UL] = 1'b1; end
            3'd4: begin d[GATE_WH] = 1'b1; d[GATE_UL] = 1'b1; end
            3'd5: begin d[GATE_WH] = 1'b1; d[GATE_VL] = 1'b1; end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/bldcm_deadtime_leg.sv
// One half-bridge leg: OFF/DEAD/ON_H/ON_L FSM with a dead-time counter
// and registered (pre-inversion) gate outputs.
module bldcm_deadtime_leg
    import bldcm_pkg::*;
#(
    parameter int pDeadWidth = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dem_h,
    input  logic                  dem_l,
    input  logic [pDeadWidth-1:0] dead_time,
    output logic                  gate_h,
    output logic                  gate_l
);

    logic [1:0]            state;
    logic [1:0]            nxt_state;
    logic [1:0]            arm_state;
    logic [pDeadWidth-1:0] cnt;
    logic [pDeadWidth-1:0] nxt_cnt;
    logic                  side;
    logic                  nxt_side;
    logic                  dem_any;

    assign dem_any = dem_h | dem_l;

    // A zero dead time skips DEAD so the gate follows the demand by one clock.
    assign arm_state = (dead_time == '0) ? (dem_l ? LEG_ON_L : LEG_ON_H)
                                         : LEG_DEAD;

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_side  = side;
        if (dem_h && dem_l) begin
            nxt_state = LEG_OFF;
        end else begin
            case (state)
                LEG_OFF: begin
                    if (dem_any) begin
                        nxt_state = arm_state;
                        nxt_side  = dem_l;
                        nxt_cnt   = dead_time;
                    end
                end
                LEG_DEAD: begin
                    if (!dem_any) begin
                        nxt_state = LEG_OFF;
                    end else if (dem_l != side) begin
                        nxt_state = arm_state;
                        nxt_side  = dem_l;
                        nxt_cnt   = dead_time;
                    end else if (cnt <= pDeadWidth'(1)) begin
                        nxt_state = side ? LEG_ON_L : LEG_ON_H;
                    end else begin
                        nxt_cnt = cnt - pDeadWidth'(1);
                    end
                end
                LEG_ON_H: begin
                    if (!dem_any) begin
                        nxt_state = LEG_OFF;
                    end else if (dem_l) begin
                        nxt_state = arm_state;
                        nxt_side  = 1'b1;
                        nxt_cnt   = dead_time;
                    end
                end
                LEG_ON_L: begin
                    if (!dem_any) begin
                        nxt_state = LEG_OFF;
                    end else if (dem_h) begin
                        nxt_state = arm_state;
                        nxt_side  = 1'b0;
                        nxt_cnt   = dead_time;
                    end
                end
                default: nxt_state = LEG_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= LEG_OFF;
            cnt    <= '0;
            side   <= 1'b0;
            gate_h <= 1'b0;
            gate_l <= 1'b0;
        end else begin
            state  <= nxt_state;
            cnt    <= nxt_cnt;
            side   <= nxt_side;
            gate_h <= (nxt_state == LEG_ON_H);
            gate_l <= (nxt_state == LEG_ON_L);
        end
    end

endmodule

// File: rtl/bldcm_ramp_core.sv
// Six-step BLDC commutation core with divider ramp and per-leg dead time.
// Define MBLDCM_RAMP_EN to slew the divider; otherwise it tracks the target.
module bldcm_ramp_core
    import bldcm_pkg::*;
#(
    parameter int unsigned pDivWidth   = 32,
    parameter int unsigned pDeadWidth  = 8,
    parameter int unsigned pStartDiv   = 100000,
    parameter logic [5:0]  pInvertMask = 6'b000000
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iEnable,
    input  logic                  iStop,
    input  logic                  iDirection,
    input  logic [pDivWidth-1:0]  iTargetDiv,
    input  logic [pDivWidth-1:0]  iRampStep,
    input  logic [pDeadWidth-1:0] iDeadTime,
    input  logic                  iPhaseLoad,
    input  logic [2:0]            iPhaseLoadValue,
    output logic [2:0]            oPhase,
    output logic [pDivWidth-1:0]  oCurDiv,
    output logic                  oRampDone,
    output logic                  oUh,
    output logic                  oUl,
    output logic                  oVh,
    output logic                  oVl,
    output logic                  oWh,
    output logic                  oWl
);

    localparam logic [pDivWidth-1:0] START_DIV = pDivWidth'(pStartDiv);

    logic [2:0]           phase;
    logic [2:0]           phase_step;
    logic [2:0]           load_phase;
    logic [pDivWidth-1:0] cnt;
    logic [pDivWidth-1:0] cur_div;
    logic [pDivWidth-1:0] tgt_eff;
    logic [pDivWidth-1:0] next_div;
    logic                 ramp_done;
    logic                 at_end;
    logic                 advance;
    logic [5:0]           dem;
    logic [5:0]           gate;

    assign tgt_eff    = (iTargetDiv == '0) ? pDivWidth'(1) : iTargetDiv;
    assign at_end     = cnt >= cur_div - pDivWidth'(1);
    assign advance    = !iPhaseLoad && !iStop && at_end;
    assign load_phase = (iPhaseLoadValue > PHASE_MAX) ? 3'd0 : iPhaseLoadValue;

    always_comb begin
        if (iDirection)
            phase_step = (phase == 3'd0) ? PHASE_MAX : phase - 3'd1;
        else
            phase_step = (phase == PHASE_MAX) ? 3'd0 : phase + 3'd1;
    end

`ifdef MBLDCM_RAMP_EN
    logic [pDivWidth:0] cur_x;
    logic [pDivWidth:0] tgt_x;
    logic [pDivWidth:0] step_x;

    assign cur_x  = {1'b0, cur_div};
    assign tgt_x  = {1'b0, tgt_eff};
    assign step_x = {1'b0, iRampStep};

    // Extra bit keeps the step comparisons free of wrap-around.
    always_comb begin
        next_div = cur_div;
        if (advance) begin
            if (cur_x > tgt_x) begin
                if (step_x >= cur_x - tgt_x)
                    next_div = tgt_eff;
                else
                    next_div = cur_div - iRampStep;
            end else if (cur_x < tgt_x) begin
                if (step_x >= tgt_x - cur_x)
                    next_div = tgt_eff;
                else
                    next_div = cur_div + iRampStep;
            end
        end
    end
`else
    logic unused_step;
    assign unused_step = ^iRampStep;
    assign next_div    = tgt_eff;
`endif

    always_ff @(posedge iClock) begin
        if (iReset) begin
            phase     <= 3'd0;
            cnt       <= '0;
            cur_div   <= START_DIV;
            ramp_done <= 1'b0;
        end else begin
            cur_div   <= next_div;
            ramp_done <= (next_div == tgt_eff);
            if (iPhaseLoad) begin
                phase <= load_phase;
                cnt   <= '0;
            end else if (iStop) begin
                cnt <= '0;
            end else if (at_end) begin
                cnt   <= '0;
                phase <= phase_step;
            end else begin
                cnt <= cnt + pDivWidth'(1);
            end
        end
    end

    assign dem = iEnable ? demand_of(phase) : 6'b000000;

    bldcm_deadtime_leg #(.pDeadWidth(pDeadWidth)) u_leg (
        .clk(iClock), .rst(iReset),
        .dem_h(dem[GATE_UH]), .dem_l(dem[GATE_UL]),
        .dead_time(iDeadTime),
        .gate_h(gate[GATE_UH]), .gate_l(gate[GATE_UL])
    );

    bldcm_deadtime_leg #(.pDeadWidth(pDeadWidth)) v_leg (
        .clk(iClock), .rst(iReset),
        .dem_h(dem[GATE_VH]), .dem_l(dem[GATE_VL]),
        .dead_time(iDeadTime),
        .gate_h(gate[GATE_VH]), .gate_l(gate[GATE_VL])
    );

    bldcm_deadtime_leg #(.pDeadWidth(pDeadWidth)) w_leg (
        .clk(iClock), .rst(iReset),
        .dem_h(dem[GATE_WH]), .dem_l(dem[GATE_WL]),
        .dead_time(iDeadTime),
        .gate_h(gate[GATE_WH]), .gate_l(gate[GATE_WL])
    );

    assign oPhase    = phase;
    assign oCurDiv   = cur_div;
    assign oRampDone = ramp_done;
    assign oUh = gate[GATE_UH] ^ pInvertMask[GATE_UH];
    assign oUl = gate[GATE_UL] ^ pInvertMask[GATE_UL];
    assign oVh = gate[GATE_VH] ^ pInvertMask[GATE_VH];
    assign oVl = gate[GATE_VL] ^ pInvertMask[GATE_VL];
    assign oWh = gate[GATE_WH] ^ pInvertMask[GATE_WH];
    assign oWl = gate[GATE_WL] ^ pInvertMask[GATE_WL];

endmodule
